// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the 3:8 select decoder.
// Holds each grant until done or timeout, then rotates priority.
module rr_select_arbiter #(
  parameter int N_REQ   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] TLAST =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] last_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nx;
  logic             found;
  logic             valid_nx;
  logic             to_nx;
  logic             expire;

  // Search starts just after the last winner and wraps modulo N_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_idx + IDX_W'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign expire = (TIMEOUT != 0) && (timer == TLAST);

  always_comb begin
    state_nx = state;
    last_nx  = last_idx;
    idx_nx   = grant_idx;
    valid_nx = grant_valid;
    timer_nx = timer;
    to_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && found) begin
          idx_nx   = winner;
          valid_nx = 1'b1;
          timer_nx = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        timer_nx = (timer == TMAX) ? timer : timer + 1'b1;
        if (done || expire) begin
          valid_nx = 1'b0;
          last_nx  = grant_idx;
          timer_nx = '0;
          state_nx = IDLE;
          to_nx    = !done;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_idx    <= '1;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      timer       <= '0;
    end else begin
      state       <= state_nx;
      last_idx    <= last_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      timeout     <= to_nx;
      timer       <= timer_nx;
    end
  end

  assign busy = grant_valid;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboard bench for rr_select_arbiter (TIMEOUT=4).
// Stimulus queues expected outputs; a monitor pops and compares.
module tb_rr_select_arbiter;

  typedef struct packed {
    logic       v;
    logic [2:0] i;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic       busy;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  rr_select_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .done       (done),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int n,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h",
               nm, n, act, exp);
    end
  endtask

  // Outputs after edge are checked against the vector driven before it.
  initial begin : monitor
    exp_t x;
    int   n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("grant_valid", n, {7'd0, grant_valid}, {7'd0, x.v});
        chk("grant_idx", n, {5'd0, grant_idx}, {5'd0, x.i});
        chk("timeout", n, {7'd0, timeout}, {7'd0, x.t});
        chk("busy", n, {7'd0, busy}, {7'd0, x.v});
        n++;
      end
    end
  end

  task automatic step(input logic r, input logic e,
                      input logic [7:0] rq, input logic d,
                      input logic ev, input logic [2:0] ei,
                      input logic et);
    @(negedge clk);
    rst  = r;
    en   = e;
    req  = rq;
    done = d;
    q.push_back('{ev, ei, et});
  endtask

  initial begin : stim
    step(1, 0, 8'h00, 0, 0, 3'd0, 0);
    step(1, 0, 8'h00, 0, 0, 3'd0, 0);
    repeat (5) step(0, 1, 8'h00, 0, 0, 3'd0, 0);

    step(0, 1, 8'h20, 0, 1, 3'd5, 0);
    step(0, 1, 8'h20, 0, 1, 3'd5, 0);
    step(0, 1, 8'h20, 0, 1, 3'd5, 0);
    step(0, 1, 8'h20, 1, 0, 3'd5, 0);
    step(0, 1, 8'h20, 0, 1, 3'd5, 0);
    step(0, 1, 8'h00, 1, 0, 3'd5, 0);

    step(1, 0, 8'h00, 0, 0, 3'd0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 8'hFF, 0, 1, 3'(i % 8), 0);
      step(0, 1, 8'hFF, 1, 0, 3'(i % 8), 0);
    end

    step(0, 1, 8'h40, 0, 1, 3'd6, 0);
    step(0, 1, 8'h00, 1, 0, 3'd6, 0);
    step(0, 1, 8'h45, 0, 1, 3'd0, 0);
    step(0, 1, 8'h45, 1, 0, 3'd0, 0);
    step(0, 1, 8'h45, 0, 1, 3'd2, 0);
    step(0, 1, 8'h00, 1, 0, 3'd2, 0);

    step(0, 1, 8'h08, 0, 1, 3'd3, 0);
    step(0, 0, 8'h00, 0, 1, 3'd3, 0);
    step(0, 0, 8'h00, 0, 1, 3'd3, 0);
    step(0, 0, 8'h00, 0, 1, 3'd3, 0);
    step(0, 0, 8'h00, 0, 0, 3'd3, 1);
    step(0, 0, 8'h00, 0, 0, 3'd3, 0);

    step(0, 1, 8'h08, 0, 1, 3'd3, 0);
    step(0, 1, 8'h08, 0, 1, 3'd3, 0);
    step(0, 1, 8'h08, 0, 1, 3'd3, 0);
    step(0, 1, 8'h08, 0, 1, 3'd3, 0);
    step(0, 0, 8'h00, 1, 0, 3'd3, 0);
    step(0, 0, 8'h00, 0, 0, 3'd3, 0);

    step(0, 1, 8'h10, 0, 1, 3'd4, 0);
    step(1, 1, 8'h10, 0, 0, 3'd0, 0);
    repeat (3) step(0, 0, 8'hFF, 0, 0, 3'd0, 0);
    step(0, 1, 8'hFF, 0, 1, 3'd0, 0);
    step(0, 1, 8'h00, 1, 0, 3'd0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
